// File: rtl/mac_csr_bank_if.sv
// Simple CSR bus between the AXI4-Lite bridge and the MAC engine.
// Read data and both error flags are combinational responses to the strobes.
interface mac_csr_bank_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              ren;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              waddr_error;
    logic              raddr_error;

    modport master (
        output addr, ren, wen, wdata,
        input  rdata, waddr_error, raddr_error
    );

    modport slave (
        input  addr, ren, wen, wdata,
        output rdata, waddr_error, raddr_error
    );
endinterface

// File: rtl/mac_csr_bank.sv
// CSR-mapped multiply-accumulate engine: RESULT[ch] = F1*F2 + A1 per channel,
// optionally chaining each channel onto the previous result (dot product).
//
// state  | meaning
// S_IDLE | waiting for a start write
// S_MUL  | registering F1[ch]*F2[ch]
// S_ACC  | writing RESULT[ch], advancing or finishing
// S_DONE | one cycle after the last ACC, done already visible
module mac_csr_bank #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    mac_csr_bank_if.slave bus,
    output logic          irq
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] CH_BASE = ADDR_W'(256);
    localparam logic [ADDR_W-1:0] CH_SPAN = ADDR_W'(16 * NUM_CH);
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              done_q, done_d;
    logic              busy;
    logic [DATA_W-1:0] f1_q  [NUM_CH];
    logic [DATA_W-1:0] f2_q  [NUM_CH];
    logic [DATA_W-1:0] a1_q  [NUM_CH];
    logic [DATA_W-1:0] res_q [NUM_CH];
    logic [DATA_W-1:0] prod_q;
    logic [DATA_W-1:0] addend;
    logic              irq_en_q, chain_cfg_q, chain_run_q, wr_blocked_q;

    logic [ADDR_W-1:0] word_addr, ch_off;
    logic              is_ctrl, is_status, in_ch, unmapped;
    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        reg_sel;
    logic              ctrl_wr, start_ok, clr_done;
    logic [DATA_W-1:0] rd_val;

    assign word_addr = bus.addr & ~ADDR_W'(3);
    assign ch_off    = word_addr - CH_BASE;
    assign is_ctrl   = (word_addr == ADDR_W'(0));
    assign is_status = (word_addr == ADDR_W'(4));
    assign in_ch     = (word_addr >= CH_BASE) && (ch_off < CH_SPAN);
    assign unmapped  = !(is_ctrl || is_status || in_ch);
    assign ch_sel    = ch_off[CH_W+3:4];
    assign reg_sel   = ch_off[3:2];

    assign busy     = (state_q == S_MUL) || (state_q == S_ACC);
    assign ctrl_wr  = bus.wen && is_ctrl;
    assign start_ok = ctrl_wr && bus.wdata[0] && !busy;
    assign clr_done = ctrl_wr && bus.wdata[1];

    // Chained runs fold the previous channel's fresh result in place of A1.
    assign addend = (chain_run_q && (ch_q != '0)) ? res_q[ch_q - CH_W'(1)] : a1_q[ch_q];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        done_d  = done_q;
        if (clr_done) done_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = S_MUL;
                    ch_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: state_d = S_ACC;
            S_ACC: begin
                if (ch_q == CH_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_MUL;
                    ch_d    = ch_q + CH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                f1_q[i]  <= '0;
                f2_q[i]  <= '0;
                a1_q[i]  <= '0;
                res_q[i] <= '0;
            end
            prod_q       <= '0;
            irq_en_q     <= 1'b0;
            chain_cfg_q  <= 1'b0;
            chain_run_q  <= 1'b0;
            wr_blocked_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q    <= bus.wdata[2];
                chain_cfg_q <= bus.wdata[3];
            end
            if (start_ok) chain_run_q <= bus.wdata[3];
            if (clr_done) wr_blocked_q <= 1'b0;
            if (bus.wen && in_ch && (reg_sel != 2'd3)) begin
                if (busy) begin
                    wr_blocked_q <= 1'b1;
                end else begin
                    case (reg_sel)
                        2'd0:    f1_q[ch_sel] <= bus.wdata;
                        2'd1:    f2_q[ch_sel] <= bus.wdata;
                        default: a1_q[ch_sel] <= bus.wdata;
                    endcase
                end
            end
            if (state_q == S_MUL) prod_q <= f1_q[ch_q] * f2_q[ch_q];
            if (state_q == S_ACC) res_q[ch_q] <= prod_q + addend;
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_ctrl) begin
            rd_val[2] = irq_en_q;
            rd_val[3] = chain_cfg_q;
        end else if (is_status) begin
            rd_val[0]    = busy;
            rd_val[1]    = done_q;
            rd_val[2]    = wr_blocked_q;
            rd_val[15:8] = 8'(ch_q);
        end else if (in_ch) begin
            case (reg_sel)
                2'd0:    rd_val = f1_q[ch_sel];
                2'd1:    rd_val = f2_q[ch_sel];
                2'd2:    rd_val = a1_q[ch_sel];
                default: rd_val = res_q[ch_sel];
            endcase
        end
    end

    assign bus.rdata       = bus.ren ? rd_val : '0;
    assign bus.raddr_error = bus.ren && unmapped;
    assign bus.waddr_error = bus.wen && (unmapped || is_status || (in_ch && (reg_sel == 2'd3)));
    assign irq             = done_q && irq_en_q;
endmodule
